sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the fetch stage (instruction requester) and the execute/memory stages (data requester).
- Sits between the pipeline stage units and the external SRAM.
- Issues at most one access per cycle and routes each 1-cycle-latency response back to its owner.
- Default priority: data over instruction. An optional starvation guard bounds how long fetch can wait.

Parameters:
- ADDR_W, 32, address width of both requesters and the SRAM.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, cycles fetch may be denied while requesting before it is forced to win (used only with the optional feature); must be >= 1.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch read request, held until accepted.
- inst_addr  in  ADDR_W  fetch address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch read data valid this cycle.
- inst_rdata  out  DATA_W  fetch read data.
- data_req  in  1  data request, held until accepted.
- data_wr  in  1  1 = write, 0 = read.
- data_wstrb  in  4  byte write strobes.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  write data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  data access complete; read data valid.
- data_rdata  out  DATA_W  data read data.
- sram_en  out  1  SRAM access enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data; valid one cycle after sram_en.

Behaviour:
- Grant logic is combinational on the current request inputs and the registered state.
- Grant rule: grant_d = data_req; grant_i = inst_req & ~data_req. At most one grant per cycle.
- addr_ok outputs:
  - inst_addr_ok = grant_i; data_addr_ok = grant_d.
  - A request is accepted in exactly the cycle its addr_ok is 1.
  - The requester must hold req and its payload stable until addr_ok.
- SRAM side:
  - sram_en = grant_i | grant_d.
  - sram_addr = data_addr if grant_d, else inst_addr.
  - sram_we = data_wstrb if (grant_d & data_wr), else 4'b0.
  - sram_wdata = data_wdata.
  - When neither is granted: sram_en = 0, sram_we = 0, sram_addr = inst_addr (don't-care).
- Response tracking: registered resp_valid, resp_owner (0 = inst, 1 = data) and resp_wr, loaded every cycle from that cycle's grant.
- Response outputs, one cycle after grant:
  - inst_data_ok = resp_valid & ~resp_owner.
  - data_data_ok = resp_valid & resp_owner. This applies to writes too; data_rdata is don't-care on write responses.
  - inst_rdata = data_rdata = sram_rdata, passed through combinationally.
- Latency and throughput: fixed 1 cycle from addr_ok to data_ok. Back-to-back grants are allowed every cycle, so there is at most one response in flight. Requesters accept data_ok unconditionally; there is no response back-pressure.
- Simultaneous requests: data wins; fetch waits with inst_addr_ok = 0 until data_req drops.
- A write with data_wstrb = 0 is still a granted access: sram_en = 1, sram_we = 0, data_data_ok the next cycle.
- Reset behaviour:
  - While reset = 1: both addr_ok = 0, sram_en = 0, sram_we = 0, and no grant is issued.
  - On the next edge: resp_valid <= 0 and starvation counter <= 0.
  - Both data_ok = 0 in the first cycle after reset deasserts.
  - A response pending when reset asserts is dropped and never signalled.

Optional Feature:
- Macro: SRAM_ARB_STARVE_GUARD_EN.
- Enabled:
  - Register starve_cnt, width clog2(STARVE_LIMIT+1).
  - Increments, saturating at STARVE_LIMIT, on each cycle with inst_req & ~grant_i.
  - Clears to 0 on grant_i or when inst_req = 0.
  - When starve_cnt == STARVE_LIMIT and inst_req = 1, priority flips: grant_i = 1, grant_d = 0 for that cycle; data_req is held and granted the following cycle.
- Disabled: no counter; pure data-over-instruction priority as above.

Test Plan:
- inst_req only, inst_addr=0x1C000000 for 3 cycles, sram_rdata = 0x02800000/…04/…08 -> inst_addr_ok=1 each cycle, sram_en=1, inst_data_ok=1 one cycle later each time, inst_rdata matches in order.
- inst_req and data_req(rd, addr 0x100) in the same cycle -> data_addr_ok=1, inst_addr_ok=0, sram_addr=0x100; next cycle inst_addr_ok=1 and data_data_ok=1.
- data write addr 0x200, wstrb=4'b0011, wdata=0xAABBCCDD -> sram_we=4'b0011, sram_wdata=0xAABBCCDD; next cycle data_data_ok=1, inst_data_ok=0.
- Reset asserted in the cycle after a data read grant -> no data_data_ok; sram_en=0 and both addr_ok=0 during reset; first post-reset cycle has both data_ok=0.
- Guard enabled, STARVE_LIMIT=4, data_req held 10 cycles with inst_req held -> inst_addr_ok=1 in cycle 5, data_addr_ok=0 in that cycle only, counter back to 0; guard disabled -> inst waits all 10 cycles.
- Alternate data_req/inst_req every cycle for 20 cycles -> exactly one addr_ok per cycle, and every addr_ok followed by exactly one matching data_ok one cycle later.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter between fetch (inst) and data requesters; data wins by default.
// Optional fetch starvation guard enabled by defining SRAM_ARB_STARVE_GUARD_EN.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("sram_port_arbiter: STARVE_LIMIT must be >= 1");
  end

  logic grant_i;
  logic grant_d;
  logic starved;
  logic resp_valid;
  logic resp_owner;
  logic resp_wr;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign starved = inst_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts consecutive cycles fetch is denied; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!inst_req || grant_i) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign starved = 1'b0;
`endif

  // A starved fetch overrides the normal data-first priority for one cycle.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      if (starved) begin
        grant_i = 1'b1;
      end else begin
        grant_d = data_req;
        grant_i = inst_req & ~data_req;
      end
    end
  end

  assign inst_addr_ok = grant_i;
  assign data_addr_ok = grant_d;

  assign sram_en    = grant_i | grant_d;
  assign sram_addr  = grant_d ? data_addr : inst_addr;
  assign sram_we    = (grant_d & data_wr) ? data_wstrb : 4'b0000;
  assign sram_wdata = data_wdata;

  // One access in flight at most; remember who owns the next-cycle response.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
      resp_wr    <= 1'b0;
    end else begin
      resp_valid <= grant_i | grant_d;
      resp_owner <= grant_d;
      resp_wr    <= grant_d & data_wr;
    end
  end

  // Gating with reset drops a response whose cycle coincides with reset.
  assign inst_data_ok = resp_valid & ~resp_owner & ~reset;
  assign data_data_ok = resp_valid &  resp_owner & ~reset;

  assign inst_rdata = sram_rdata;
  assign data_rdata = resp_wr ? '0 : sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a request-level behavioural model.
module tb_sram_port_arbiter;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req;
  logic              data_wr;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic [DATA_W-1:0] rd_value;

  int total = 0;
  int bad   = 0;

  // model-visible grant decisions for the requester side
  bit m_gi = 0;
  bit m_gd = 0;

  sram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM stand-in: data presented the cycle after an enabled access.
  always @(posedge clk) begin
    if (sram_en) sram_rdata <= rd_value;
    else         sram_rdata <= $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending response slot plus a count of consecutive fetch denials.
  bit          pend_v = 0;
  bit          pend_d = 0;
  bit          pend_wr = 0;
  logic [31:0] pend_data = '0;
  int          denied = 0;

  always @(negedge clk) begin
    bit gi, gd, force_i;
    bit e_iok, e_dok;
    e_iok = pend_v && !pend_d && !reset;
    e_dok = pend_v &&  pend_d && !reset;
    check("inst_data_ok", 32'(inst_data_ok), 32'(e_iok));
    check("data_data_ok", 32'(data_data_ok), 32'(e_dok));
    if (e_iok) check("inst_rdata", inst_rdata, pend_data);
    if (e_dok && !pend_wr) check("data_rdata", data_rdata, pend_data);

    force_i = 0;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    force_i = inst_req && (denied >= STARVE_LIMIT);
`endif
    if (reset)        begin gi = 0; gd = 0; end
    else if (force_i) begin gi = 1; gd = 0; end
    else              begin gd = data_req; gi = inst_req && !data_req; end

    check("inst_addr_ok", 32'(inst_addr_ok), 32'(gi));
    check("data_addr_ok", 32'(data_addr_ok), 32'(gd));
    check("sram_en", 32'(sram_en), 32'(gi || gd));
    check("sram_we", 32'(sram_we), (gd && data_wr) ? 32'(data_wstrb) : 32'd0);
    check("sram_addr", sram_addr, gd ? data_addr : inst_addr);
    check("sram_wdata", sram_wdata, data_wdata);

    pend_v    = !reset && (gi || gd);
    pend_d    = gd;
    pend_wr   = gd && data_wr;
    pend_data = rd_value;
    if (reset || !inst_req || gi) denied = 0;
    else                          denied++;
    m_gi = gi;
    m_gd = gd;
  end

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid_cyc();
    @(negedge clk); #1;
  endtask

  bit guard_on;
  bit prev_data;

  initial begin
`ifdef SRAM_ARB_STARVE_GUARD_EN
    guard_on = 1;
`else
    guard_on = 0;
`endif
    reset = 1; inst_req = 1; inst_addr = 32'h1000; data_req = 1; data_wr = 1;
    data_wstrb = 4'hF; data_addr = 32'h80; data_wdata = 32'h1234_5678; rd_value = '0;

    // requests present while reset is held must not be granted
    next_cyc(); mid_cyc();
    check("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    check("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
    check("rst_sram_en", 32'(sram_en), 32'd0);
    check("rst_sram_we", 32'(sram_we), 32'd0);
    next_cyc();
    reset = 0; inst_req = 0; data_req = 0; data_wr = 0;
    mid_cyc();
    check("post_rst_iok", 32'(inst_data_ok), 32'd0);
    check("post_rst_dok", 32'(data_data_ok), 32'd0);

    // back-to-back fetches
    next_cyc();
    inst_req = 1; inst_addr = 32'h1C00_0000;
    for (int k = 0; k < 3; k++) begin
      rd_value = 32'h0280_0000 + 32'(4 * k);
      mid_cyc();
      check("fetch_addr_ok", 32'(inst_addr_ok), 32'd1);
      check("fetch_sram_en", 32'(sram_en), 32'd1);
      if (k > 0) begin
        check("fetch_data_ok", 32'(inst_data_ok), 32'd1);
        check("fetch_rdata", inst_rdata, 32'h0280_0000 + 32'(4 * (k - 1)));
      end
      next_cyc();
    end
    inst_req = 0;
    mid_cyc();
    check("fetch_last_ok", 32'(inst_data_ok), 32'd1);
    check("fetch_last_rdata", inst_rdata, 32'h0280_0008);

    // simultaneous requests: data first, fetch next
    next_cyc();
    inst_req = 1; inst_addr = 32'h1C00_0010; data_req = 1; data_wr = 0; data_addr = 32'h100;
    rd_value = 32'hCAFE_0001;
    mid_cyc();
    check("both_data_addr_ok", 32'(data_addr_ok), 32'd1);
    check("both_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    check("both_sram_addr", sram_addr, 32'h100);
    next_cyc();
    data_req = 0; rd_value = 32'hCAFE_0002;
    mid_cyc();
    check("both_inst_next", 32'(inst_addr_ok), 32'd1);
    check("both_data_ok", 32'(data_data_ok), 32'd1);
    check("both_data_rdata", data_rdata, 32'hCAFE_0001);
    next_cyc();
    inst_req = 0;

    // partial-strobe write
    data_req = 1; data_wr = 1; data_addr = 32'h200; data_wstrb = 4'b0011; data_wdata = 32'hAABB_CCDD;
    mid_cyc();
    check("wr_sram_we", 32'(sram_we), 32'h3);
    check("wr_sram_wdata", sram_wdata, 32'hAABB_CCDD);
    next_cyc();
    data_req = 0; data_wr = 0;
    mid_cyc();
    check("wr_data_ok", 32'(data_data_ok), 32'd1);
    check("wr_inst_ok", 32'(inst_data_ok), 32'd0);

    // zero-strobe write is still an access
    next_cyc();
    data_req = 1; data_wr = 1; data_wstrb = 4'b0000;
    mid_cyc();
    check("wr0_sram_en", 32'(sram_en), 32'd1);
    check("wr0_sram_we", 32'(sram_we), 32'd0);
    next_cyc();
    data_req = 0; data_wr = 0;
    mid_cyc();
    check("wr0_data_ok", 32'(data_data_ok), 32'd1);

    // reset right after a read grant drops its response
    next_cyc();
    data_req = 1; data_addr = 32'h40;
    mid_cyc();
    check("rr_grant", 32'(data_addr_ok), 32'd1);
    next_cyc();
    data_req = 0; reset = 1; inst_req = 1;
    mid_cyc();
    check("rr_no_data_ok", 32'(data_data_ok), 32'd0);
    check("rr_sram_en", 32'(sram_en), 32'd0);
    check("rr_iaok", 32'(inst_addr_ok), 32'd0);
    check("rr_daok", 32'(data_addr_ok), 32'd0);
    next_cyc();
    reset = 0; inst_req = 0;
    mid_cyc();
    check("rr_post_iok", 32'(inst_data_ok), 32'd0);
    check("rr_post_dok", 32'(data_data_ok), 32'd0);

    // fetch contending with 10 cycles of data traffic
    next_cyc();
    inst_req = 1; inst_addr = 32'h1C00_0100; data_req = 1; data_wr = 0; data_addr = 32'h300;
    for (int c = 1; c <= 10; c++) begin
      bit want_i;
      want_i = guard_on && (c == STARVE_LIMIT + 1);
      mid_cyc();
      check("starve_inst_addr_ok", 32'(inst_addr_ok), 32'(want_i));
      check("starve_data_addr_ok", 32'(data_addr_ok), 32'(!want_i));
      next_cyc();
      if (want_i) inst_req = 0;
    end
    inst_req = 0; data_req = 0;

    // alternating requesters
    next_cyc();
    for (int c = 0; c < 20; c++) begin
      data_req = (c % 2 == 0);
      inst_req = (c % 2 == 1);
      mid_cyc();
      check("alt_one_grant", 32'(inst_addr_ok) + 32'(data_addr_ok), 32'd1);
      if (c > 0) begin
        check("alt_dok", 32'(data_data_ok), 32'(prev_data));
        check("alt_iok", 32'(inst_data_ok), 32'(!prev_data));
      end
      prev_data = data_addr_ok;
      next_cyc();
    end
    inst_req = 0; data_req = 0;

    // randomized traffic with protocol-compliant holding
    for (int n = 0; n < 600; n++) begin
      next_cyc();
      rd_value = $urandom;
      reset = ($urandom_range(0, 59) == 0);
      if (!inst_req || m_gi) begin
        inst_req  = ($urandom_range(0, 2) != 0);
        inst_addr = $urandom;
      end
      if (!data_req || m_gd) begin
        data_req   = ($urandom_range(0, 1) != 0);
        data_wr    = $urandom_range(0, 1) != 0;
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
    end
    next_cyc();
    reset = 0; inst_req = 0; data_req = 0;
    repeat (3) next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
